mem_port_arbiter: RTL and testbench

- Shares the accelerator's single-port SRAM between two requesters: requester 0 is the Wishbone debug path (wbs_mem_*), requester 1 is the accelerator core's load/store unit.
- Round-robin arbitration by default; an optional core-priority mode favours the core, with a starvation bound that still guarantees debug access.
- Tracks in-flight reads so each read response returns only to the requester that issued it.
- Sits between the accelerator datapath and the SRAM macro, in the user_proj_clk domain.

---
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port SRAM between the Wishbone debug path
// (requester 0) and the accelerator load/store unit (requester 1).
//
// Arbitration is round-robin by default. With core_prio = 1 the core wins ties,
// but requester 0 is granted once it has been blocked for MAX_WAIT cycles.
// A tag pipe of READ_LATENCY stages follows each accepted read, so its SRAM
// data is returned only to the requester that issued it.
//
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   core_prio           1 = requester 1 favoured, 0 = round-robin
//   reqN_vld/rdy        request handshake; rdy is the same-cycle grant
//   reqN_we/addr/wdata  request fields, held stable by the requester until rdy
//   respN_vld/rdata     read response; rdata is 0 when vld is 0
//   mem_en/we/addr/wdata  SRAM access, all zero when no access is made
//   mem_rdata           SRAM read data, valid READ_LATENCY cycles after access
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 12,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned MAX_WAIT     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_prio,

  input  logic              req0_vld,
  output logic              req0_rdy,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              resp0_vld,
  output logic [DATA_W-1:0] resp0_rdata,

  input  logic              req1_vld,
  output logic              req1_rdy,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              resp1_vld,
  output logic [DATA_W-1:0] resp1_rdata,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned LAST_ST = READ_LATENCY - 1;

  // State: last granted id, requester-0 blocked counter, read tag pipe
  logic                    r_last_gnt;
  logic [CNT_W-1:0]        r_wait_cnt;
  logic [READ_LATENCY-1:0] r_tag_vld;
  logic [READ_LATENCY-1:0] r_tag_id;

  logic             w_tie0;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_out_vld;
  logic [CNT_W-1:0] w_wait_cnt_nxt;

  // Grant decision and SRAM request mux
  always_comb begin
    w_tie0      = 1'b0;
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    req0_rdy    = 1'b0;
    req1_rdy    = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;

    // Who wins when both are valid: starvation bound in core-priority mode,
    // otherwise the requester that was not granted last.
    if (core_prio) begin
      w_tie0 = (r_wait_cnt == CNT_W'(MAX_WAIT));
    end else begin
      w_tie0 = r_last_gnt;
    end

    w_gnt0 = !rst && req0_vld && (!req1_vld || w_tie0);
    w_gnt1 = !rst && req1_vld && !w_gnt0;

    req0_rdy = w_gnt0;
    req1_rdy = w_gnt1;

    if (w_gnt0) begin
      mem_en    = 1'b1;
      mem_we    = req0_we;
      mem_addr  = req0_addr;
      mem_wdata = req0_wdata;
    end else if (w_gnt1) begin
      mem_en    = 1'b1;
      mem_we    = req1_we;
      mem_addr  = req1_addr;
      mem_wdata = req1_wdata;
    end
  end

  // Blocked-cycle counter for requester 0, saturating
  always_comb begin
    w_wait_cnt_nxt = '0;
    if (req0_vld && !w_gnt0) begin
      if (r_wait_cnt == {CNT_W{1'b1}}) begin
        w_wait_cnt_nxt = r_wait_cnt;
      end else begin
        w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
      end
    end
  end

  // Response routing from the oldest tag stage
  always_comb begin
    w_out_vld   = r_tag_vld[LAST_ST] && !rst;
    resp0_vld   = w_out_vld && !r_tag_id[LAST_ST];
    resp1_vld   = w_out_vld &&  r_tag_id[LAST_ST];
    resp0_rdata = resp0_vld ? mem_rdata : '0;
    resp1_rdata = resp1_vld ? mem_rdata : '0;
  end

  // State registers; reset drops any in-flight read tags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_gnt <= 1'b1;
      r_wait_cnt <= '0;
      r_tag_vld  <= '0;
      r_tag_id   <= '0;
    end else begin
      if (w_gnt0 || w_gnt1) begin
        r_last_gnt <= w_gnt1;
      end
      r_wait_cnt   <= w_wait_cnt_nxt;
      r_tag_vld[0] <= mem_en && !mem_we;
      r_tag_id[0]  <= w_gnt1;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_id[i]  <= r_tag_id[i-1];
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Three instances share the request
// inputs and differ only in READ_LATENCY (1, 2, 3); a common SRAM array is
// written by instance a and read through a per-instance latency pipe.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        core_prio = 1'b0;
  logic        req0_vld = 1'b0, req0_we = 1'b0;
  logic [11:0] req0_addr = '0;
  logic [31:0] req0_wdata = '0;
  logic        req1_vld = 1'b0, req1_we = 1'b0;
  logic [11:0] req1_addr = '0;
  logic [31:0] req1_wdata = '0;

  logic        rdy0_a, rdy1_a, r0v_a, r1v_a, en_a, we_a;
  logic [31:0] r0d_a, r1d_a, wd_a, rd_a;
  logic [11:0] ad_a;
  logic        rdy0_b, rdy1_b, r0v_b, r1v_b, en_b, we_b;
  logic [31:0] r0d_b, r1d_b, wd_b, rd_b;
  logic [11:0] ad_b;
  logic        rdy0_c, rdy1_c, r0v_c, r1v_c, en_c, we_c;
  logic [31:0] r0d_c, r1d_c, wd_c, rd_c;
  logic [11:0] ad_c;

  logic [31:0] mem [0:4095];
  logic [31:0] b_p1, b_p2, c_p1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(12), .DATA_W(32), .READ_LATENCY(1), .MAX_WAIT(8)) u_a (
    .clk(clk), .rst(rst), .core_prio(core_prio),
    .req0_vld(req0_vld), .req0_rdy(rdy0_a), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .resp0_vld(r0v_a), .resp0_rdata(r0d_a),
    .req1_vld(req1_vld), .req1_rdy(rdy1_a), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .resp1_vld(r1v_a), .resp1_rdata(r1d_a),
    .mem_en(en_a), .mem_we(we_a), .mem_addr(ad_a), .mem_wdata(wd_a), .mem_rdata(rd_a));

  mem_port_arbiter #(.ADDR_W(12), .DATA_W(32), .READ_LATENCY(3), .MAX_WAIT(8)) u_b (
    .clk(clk), .rst(rst), .core_prio(core_prio),
    .req0_vld(req0_vld), .req0_rdy(rdy0_b), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .resp0_vld(r0v_b), .resp0_rdata(r0d_b),
    .req1_vld(req1_vld), .req1_rdy(rdy1_b), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .resp1_vld(r1v_b), .resp1_rdata(r1d_b),
    .mem_en(en_b), .mem_we(we_b), .mem_addr(ad_b), .mem_wdata(wd_b), .mem_rdata(rd_b));

  mem_port_arbiter #(.ADDR_W(12), .DATA_W(32), .READ_LATENCY(2), .MAX_WAIT(8)) u_c (
    .clk(clk), .rst(rst), .core_prio(core_prio),
    .req0_vld(req0_vld), .req0_rdy(rdy0_c), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .resp0_vld(r0v_c), .resp0_rdata(r0d_c),
    .req1_vld(req1_vld), .req1_rdy(rdy1_c), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .resp1_vld(r1v_c), .resp1_rdata(r1d_c),
    .mem_en(en_c), .mem_we(we_c), .mem_addr(ad_c), .mem_wdata(wd_c), .mem_rdata(rd_c));

  // SRAM model: write through instance a, read pipes of depth 1, 3 and 2
  always @(posedge clk) begin
    if (en_a && we_a) mem[ad_a] <= wd_a;
    rd_a <= mem[ad_a];
    b_p1 <= mem[ad_b];
    b_p2 <= b_p1;
    rd_b <= b_p2;
    c_p1 <= mem[ad_c];
    rd_c <= c_p1;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    req0_vld = 1'b0;
    req1_vld = 1'b0;
    req0_we  = 1'b0;
    req1_we  = 1'b0;
    repeat (n) next_cycle();
  endtask

  task automatic set0(input logic v, input logic we, input logic [11:0] a, input logic [31:0] d);
    req0_vld = v; req0_we = we; req0_addr = a; req0_wdata = d;
  endtask

  task automatic set1(input logic v, input logic we, input logic [11:0] a, input logic [31:0] d);
    req1_vld = v; req1_we = we; req1_addr = a; req1_wdata = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    mem[12'h010] = 32'hDEADBEEF;
    mem[12'h100] = 32'hA0A0A0A0;
    mem[12'h200] = 32'hB0B0B0B0;
    mem[12'h300] = 32'hC0C0C0C0;

    // Reset held with a pending request: nothing granted
    set0(1'b1, 1'b0, 12'h010, 32'h0);
    @(negedge clk);
    check_eq("rst_rdy0", rdy0_a, 1'b0);
    check_eq("rst_en", en_a, 1'b0);
    check_eq("rst_addr", ad_a, 12'h000);
    check_eq("rst_resp0", r0v_a, 1'b0);
    next_cycle();
    rst = 1'b0;

    // First read after reset, latency 1
    @(negedge clk);
    check_eq("rd0_rdy0", rdy0_a, 1'b1);
    check_eq("rd0_en", en_a, 1'b1);
    check_eq("rd0_we", we_a, 1'b0);
    check_eq("rd0_addr", ad_a, 12'h010);
    check_eq("rd0_resp0_early", r0v_a, 1'b0);
    next_cycle();
    req0_vld = 1'b0;
    @(negedge clk);
    check_eq("rd0_resp0_vld", r0v_a, 1'b1);
    check_eq("rd0_resp0_data", r0d_a, 32'hDEADBEEF);
    check_eq("rd0_resp1_vld", r1v_a, 1'b0);
    check_eq("rd0_idle_en", en_a, 1'b0);
    idle_cycles(4);

    // Round-robin: lone req1 first so the contended run starts with req0
    set1(1'b1, 1'b0, 12'h002, 32'h0);
    @(negedge clk);
    check_eq("rr_solo_rdy1", rdy1_a, 1'b1);
    next_cycle();
    set0(1'b1, 1'b0, 12'h001, 32'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq($sformatf("rr_rdy0_%0d", i), rdy0_a, (i % 2 == 0));
      check_eq($sformatf("rr_rdy1_%0d", i), rdy1_a, (i % 2 == 1));
      check_eq($sformatf("rr_addr_%0d", i), ad_a, (i % 2 == 0) ? 12'h001 : 12'h002);
      next_cycle();
    end
    idle_cycles(4);

    // Core priority with starvation bound of 8
    core_prio = 1'b1;
    set0(1'b1, 1'b0, 12'h001, 32'h0);
    set1(1'b1, 1'b0, 12'h002, 32'h0);
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      check_eq($sformatf("cp_rdy0_%0d", i), rdy0_a, (i == 8));
      check_eq($sformatf("cp_rdy1_%0d", i), rdy1_a, (i != 8));
      next_cycle();
    end
    req1_vld = 1'b0;
    @(negedge clk);
    check_eq("cp_solo_rdy0", rdy0_a, 1'b1);
    next_cycle();
    core_prio = 1'b0;
    idle_cycles(4);

    // Latency 3: req1@100, req0@200, req1@300 back to back
    for (int i = 0; i < 6; i++) begin
      set0(i == 1, 1'b0, 12'h200, 32'h0);
      set1(i == 0 || i == 2, 1'b0, (i == 0) ? 12'h100 : 12'h300, 32'h0);
      @(negedge clk);
      check_eq($sformatf("l3_r1v_%0d", i), r1v_b, (i == 3 || i == 5));
      check_eq($sformatf("l3_r0v_%0d", i), r0v_b, (i == 4));
      check_eq($sformatf("l3_r1d_%0d", i), r1d_b,
               (i == 3) ? 32'hA0A0A0A0 : (i == 5) ? 32'hC0C0C0C0 : 32'h0);
      check_eq($sformatf("l3_r0d_%0d", i), r0d_b, (i == 4) ? 32'hB0B0B0B0 : 32'h0);
      next_cycle();
    end
    idle_cycles(4);

    // Write from req0 then read it back from req1
    set0(1'b1, 1'b1, 12'h0A5, 32'h12345678);
    @(negedge clk);
    check_eq("wr_rdy0", rdy0_a, 1'b1);
    check_eq("wr_we", we_a, 1'b1);
    check_eq("wr_addr", ad_a, 12'h0A5);
    check_eq("wr_wdata", wd_a, 32'h12345678);
    next_cycle();
    set0(1'b0, 1'b0, 12'h0, 32'h0);
    set1(1'b1, 1'b0, 12'h0A5, 32'h0);
    @(negedge clk);
    check_eq("wr_no_resp0", r0v_a, 1'b0);
    check_eq("wr_no_resp0_data", r0d_a, 32'h0);
    check_eq("rb_rdy1", rdy1_a, 1'b1);
    check_eq("rb_we", we_a, 1'b0);
    check_eq("rb_wdata_zero", wd_a, 32'h0);
    next_cycle();
    req1_vld = 1'b0;
    @(negedge clk);
    check_eq("rb_resp1_vld", r1v_a, 1'b1);
    check_eq("rb_resp1_data", r1d_a, 32'h12345678);
    check_eq("rb_resp0_vld", r0v_a, 1'b0);
    idle_cycles(4);

    // Reset one cycle after an accepted read on the latency-2 instance
    set0(1'b1, 1'b0, 12'h010, 32'h0);
    @(negedge clk);
    check_eq("mr_rdy0", rdy0_c, 1'b1);
    next_cycle();
    rst = 1'b1;
    req1_vld = 1'b1;
    req1_addr = 12'h002;
    @(negedge clk);
    check_eq("mr_rst_rdy0", rdy0_c, 1'b0);
    check_eq("mr_rst_rdy1", rdy1_c, 1'b0);
    check_eq("mr_rst_r0v", r0v_c, 1'b0);
    check_eq("mr_rst_r1v", r1v_c, 1'b0);
    check_eq("mr_rst_en", en_c, 1'b0);
    check_eq("mr_rst_addr", ad_c, 12'h000);
    check_eq("mr_rst_r0d", r0d_c, 32'h0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check_eq("mr_post_r0v", r0v_c, 1'b0);
    check_eq("mr_post_r1v", r1v_c, 1'b0);
    check_eq("mr_tie_rdy0", rdy0_c, 1'b1);
    check_eq("mr_tie_rdy1", rdy1_c, 1'b0);
    check_eq("mr_tie_rdy0_a", rdy0_a, 1'b1);
    next_cycle();
    idle_cycles(0);
    @(negedge clk);
    check_eq("mr_post2_r0v", r0v_c, 1'b0);
    check_eq("mr_post2_r1v", r1v_c, 1'b0);
    next_cycle();
    @(negedge clk);
    check_eq("mr_new_r0v", r0v_c, 1'b1);
    check_eq("mr_new_r0d", r0d_c, 32'hDEADBEEF);
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
